// File: rtl/tmrnbit_pkg.sv
// tmrnbit_pkg: shared definitions for the tmrnbit down-counting timer.
//   STATE_W    - width of the FSM state encoding
//   ST_IDLE    - idle, count held at 0
//   ST_RUN     - counting down
//   ST_EXPIRED - count reached 0, waiting for acknowledge
package tmrnbit_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN     = 2'd1;
  localparam logic [STATE_W-1:0] ST_EXPIRED = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    StIdle    = ST_IDLE,
    StRun     = ST_RUN,
    StExpired = ST_EXPIRED
  } state_e;

endpackage

// File: rtl/tmrnbit.sv
// tmrnbit: loadable N-bit down-counting timer with one-cycle terminal-count
// pulse and sticky expired flag.
//
// Optional feature: define TMRNBIT_AUTORELOAD_EN to reload the count from the
// last loaded value on expiry and keep running (periodic tc_o).
//
// Ports:
//   clk_i    - system clock, rising edge
//   rst_n_i  - asynchronous active-low reset
//   ld_i     - load val_i and start (restarts if running)
//   val_i    - initial count, sampled when ld_i=1
//   stop_i   - abort to IDLE, count cleared
//   pause_i  - hold count while running
//   ack_i    - acknowledge expiry (EXPIRED -> IDLE)
//   cnt_o    - remaining count
//   busy_o   - 1 while running
//   tc_o     - registered one-cycle terminal-count pulse
//   exp_o    - 1 while expired
module tmrnbit
  import tmrnbit_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         ld_i,
  input  logic [N-1:0] val_i,
  input  logic         stop_i,
  input  logic         pause_i,
  input  logic         ack_i,
  output logic [N-1:0] cnt_o,
  output logic         busy_o,
  output logic         tc_o,
  output logic         exp_o
);

  localparam logic [N-1:0] CntZero = '0;
  localparam logic [N-1:0] CntOne  = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q;
  logic [N-1:0] cnt_q;
  logic         tc_q;

`ifdef TMRNBIT_AUTORELOAD_EN
  logic [N-1:0] reload_q;
`endif

  // Priority: stop > load > ack > pause > decrement.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      cnt_q    <= CntZero;
      tc_q     <= 1'b0;
`ifdef TMRNBIT_AUTORELOAD_EN
      reload_q <= CntZero;
`endif
    end else begin
      tc_q <= 1'b0;
      if (stop_i) begin
        state_q <= StIdle;
        cnt_q   <= CntZero;
      end else if (ld_i) begin
        cnt_q <= val_i;
`ifdef TMRNBIT_AUTORELOAD_EN
        reload_q <= val_i;
`endif
        if (val_i != CntZero) begin
          state_q <= StRun;
        end else begin
          // A zero load expires immediately, even with auto-reload.
          state_q <= StExpired;
          tc_q    <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StRun: begin
            if (!pause_i) begin
              if (cnt_q > CntOne) begin
                cnt_q <= cnt_q - CntOne;
              end else begin
                tc_q <= 1'b1;
`ifdef TMRNBIT_AUTORELOAD_EN
                cnt_q <= reload_q;
`else
                cnt_q   <= CntZero;
                state_q <= StExpired;
`endif
              end
            end
          end
          StExpired: begin
            cnt_q <= CntZero;
            if (ack_i) begin
              state_q <= StIdle;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= CntZero;
          end
        endcase
      end
    end
  end

  // Flags decode from state so an asynchronous reset clears them at once.
  assign cnt_o  = cnt_q;
  assign tc_o   = tc_q;
  assign busy_o = (state_q == StRun);
  assign exp_o  = (state_q == StExpired);

endmodule

// File: tb/tb_tmrnbit.sv
// tb_tmrnbit: self-checking bench for tmrnbit. Directed steps plus a random
// phase, checked against a behavioural timer model. A second N=4 instance
// covers the narrow-width full-scale count.
module tb_tmrnbit;

`ifdef TMRNBIT_AUTORELOAD_EN
  localparam bit AutoReload = 1'b1;
`else
  localparam bit AutoReload = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld, stop, pause, ack;
  logic [15:0] val;
  logic [15:0] cnt;
  logic        busy, tc, expd;
  logic [3:0]  val4;
  logic [3:0]  cnt4;
  logic        busy4, tc4, exp4;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_cnt, m_reload;
  bit m_run, m_exp, m_tc;

  assign val4 = val[3:0];

  always #5 clk = ~clk;

  tmrnbit #(.N(16)) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .ld_i    (ld),
    .val_i   (val),
    .stop_i  (stop),
    .pause_i (pause),
    .ack_i   (ack),
    .cnt_o   (cnt),
    .busy_o  (busy),
    .tc_o    (tc),
    .exp_o   (expd)
  );

  tmrnbit #(.N(4)) u_dut4 (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .ld_i    (ld),
    .val_i   (val4),
    .stop_i  (stop),
    .pause_i (pause),
    .ack_i   (ack),
    .cnt_o   (cnt4),
    .busy_o  (busy4),
    .tc_o    (tc4),
    .exp_o   (exp4)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_reload = 0; m_run = 0; m_exp = 0; m_tc = 0;
  endtask

  // One clock of timer behaviour, stated in terms of the timer's rules.
  task automatic model_step();
    m_tc = 0;
    if (stop) begin
      m_run = 0; m_exp = 0; m_cnt = 0;
    end else if (ld) begin
      m_cnt = int'(val); m_reload = int'(val);
      if (val == 0) begin
        m_run = 0; m_exp = 1; m_tc = 1;
      end else begin
        m_run = 1; m_exp = 0;
      end
    end else if (m_run) begin
      if (!pause) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_tc = 1;
          if (AutoReload) m_cnt = m_reload;
          else begin
            m_run = 0; m_exp = 1;
          end
        end
      end
    end else if (m_exp && ack) begin
      m_exp = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cnt"},  int'(cnt),  m_cnt);
    chk({tag, ".busy"}, int'(busy), int'(m_run));
    chk({tag, ".tc"},   int'(tc),   int'(m_tc));
    chk({tag, ".exp"},  int'(expd), int'(m_exp));
  endtask

  task automatic tick(input string tag, input bit l, input int v, input bit s,
                      input bit p, input bit a);
    ld = l; val = 16'(v); stop = s; pause = p; ack = a;
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  initial begin
    int first;
    ld = 0; val = '0; stop = 0; pause = 0; ack = 0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Load 5, run to expiry, then acknowledge
    tick("ld5", 1, 5, 0, 0, 0);
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      tick("run5", 0, 0, 0, 0, 0);
      if (tc && first == 0) first = k;
    end
    chk("tc_latency_5", first, 5);
    tick("ack5", 0, 0, 0, 0, 1);
    tick("idle", 0, 0, 0, 0, 0);

    // Load 4 with a 3-cycle pause mid-count
    tick("ld4", 1, 4, 0, 0, 0);
    first = 0;
    for (int k = 1; k <= 10; k++) begin
      tick("pause4", 0, 0, 0, (k >= 2 && k <= 4), 0);
      if (tc && first == 0) first = k;
    end
    chk("tc_latency_pause", first, 7);
    tick("ack4", 0, 0, 1, 0, 0);

    // Zero load expires immediately
    tick("ld0", 1, 0, 0, 0, 0);
    chk("ld0_tc", int'(tc), 1);
    tick("ld0_hold", 0, 0, 0, 0, 0);
    tick("ld0_ack", 0, 0, 0, 0, 1);
    chk("ld0_exp_clr", int'(expd), 0);

    // Restart at cnt=2 with val=3
    tick("ld10", 1, 10, 0, 0, 0);
    for (int k = 1; k <= 8; k++) tick("run10", 0, 0, 0, 0, 0);
    chk("restart_cnt", int'(cnt), 2);
    tick("ld3", 1, 3, 0, 0, 0);
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      tick("run3", 0, 0, 0, 0, 0);
      if (tc && first == 0) first = k;
    end
    chk("tc_latency_restart", first, 3);

    // Stop and load together, load on the expiry edge, stop on expiry edge
    tick("stop_ld", 1, 9, 1, 0, 0);
    chk("stop_ld_cnt", int'(cnt), 0);
    tick("ld2", 1, 2, 0, 0, 0);
    tick("dec2", 0, 0, 0, 0, 0);
    tick("ld_at_tc", 1, 3, 0, 0, 0);
    chk("ld_at_tc_no_tc", int'(tc), 0);
    tick("dec3a", 0, 0, 0, 0, 0);
    tick("dec3b", 0, 0, 0, 0, 0);
    tick("stop_at_tc", 0, 0, 1, 0, 0);
    chk("stop_at_tc_no_tc", int'(tc), 0);

    // Asynchronous reset mid-count
    tick("ld10b", 1, 10, 0, 0, 0);
    for (int k = 1; k <= 4; k++) tick("run10b", 0, 0, 0, 0, 0);
    chk("pre_rst_cnt", int'(cnt), 6);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Narrow instance: full-scale load of 15
    tick("ldF", 1, 15, 0, 0, 0);
    chk("n4_cnt", int'(cnt4), 15);
    chk("n4_busy", int'(busy4), 1);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      tick("runF", 0, 0, 0, 0, 0);
      if (tc4 && first == 0) first = k;
    end
    chk("n4_tc_latency", first, 15);
    tick("stopF", 0, 0, 1, 0, 0);

    // Periodic-reload scenario (one-shot build simply expires)
    tick("ld3r", 1, 3, 0, 0, 0);
    for (int k = 1; k <= 10; k++) tick("run3r", 0, 0, 0, 0, 0);
    tick("stop3r", 0, 0, 1, 0, 0);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      tick("rand", ($urandom_range(7) == 0), $urandom_range(12),
           ($urandom_range(19) == 0), ($urandom_range(3) == 0),
           ($urandom_range(3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
